// File: rtl/axis_arb_pkg.sv
// Shared types for the 2:1 AXI-Stream packet arbiter.
// State encodings equal the one-hot grant codes so grant is a straight register read.
package axis_arb_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S1   = 2'b01;
  localparam logic [1:0] GNT_S2   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = GNT_NONE,
    GNT1 = GNT_S1,
    GNT2 = GNT_S2
  } arb_state_t;

endpackage

// File: rtl/axis_arb_wdog.sv
// Mid-packet watchdog: counts consecutive stalled cycles while enabled and
// flags expire combinationally on the TIMEOUT-th one.
module axis_arb_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    expire = 1'b0;
    if (en && stall) begin
      if (cnt_q == LIMIT) begin
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_arb_2_1.sv
// 2:1 AXI-Stream arbiter, packet-granular round robin with one idle bubble per packet.
// Define AXIS_ARB_TIMEOUT_EN to add the mid-packet watchdog (err_timeout).
module axis_arb_2_1
  import axis_arb_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  input  logic          s1_tlast,
  output logic          s1_tready,
  input  logic [DW-1:0] s2_tdata,
  input  logic          s2_tvalid,
  input  logic          s2_tlast,
  output logic          s2_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [1:0]    grant,
  output logic          err_timeout
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("axis_arb_2_1: TIMEOUT must be in 1..255");
  end

  arb_state_t state_q, state_d;
  logic       last_s2_q, last_s2_d;
  logic       expire;

`ifdef AXIS_ARB_TIMEOUT_EN
  logic wd_en, wd_stall;

  assign wd_en    = (state_q != IDLE);
  assign wd_stall = (state_q == GNT1) ? !s1_tvalid : !s2_tvalid;

  axis_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .en    (wd_en),
    .stall (wd_stall),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign err_timeout = expire;
  assign grant       = state_q;

  // Every grant ends in IDLE, which gives the mandatory single bubble between packets.
  always_comb begin
    state_d   = state_q;
    last_s2_d = last_s2_q;
    unique case (state_q)
      IDLE: begin
        if (s1_tvalid && (!s2_tvalid || last_s2_q)) begin
          state_d = GNT1;
        end else if (s2_tvalid) begin
          state_d = GNT2;
        end
      end
      GNT1: begin
        if ((s1_tvalid && m_tready && s1_tlast) || expire) begin
          state_d   = IDLE;
          last_s2_d = 1'b0;
        end
      end
      GNT2: begin
        if ((s2_tvalid && m_tready && s2_tlast) || expire) begin
          state_d   = IDLE;
          last_s2_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s1_tready = 1'b0;
    s2_tready = 1'b0;
    unique case (state_q)
      GNT1: begin
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
      end
      GNT2: begin
        m_tdata   = s2_tdata;
        m_tvalid  = s2_tvalid;
        m_tlast   = s2_tlast;
        s2_tready = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_s2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_s2_q <= last_s2_d;
    end
  end

endmodule

// File: tb/tb_axis_arb_2_1.sv
// Scoreboard bench for axis_arb_2_1; expected beats are queued in arbitration order.
// Watchdog expectations follow AXIS_ARB_TIMEOUT_EN (TIMEOUT overridden to 4).
module tb_axis_arb_2_1;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s1_tdata, s2_tdata, m_tdata;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          s2_tvalid, s2_tlast, s2_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic          err_timeout;

  axis_arb_2_1 #(
    .DW     (DW),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s1_tdata   (s1_tdata),
    .s1_tvalid  (s1_tvalid),
    .s1_tlast   (s1_tlast),
    .s1_tready  (s1_tready),
    .s2_tdata   (s2_tdata),
    .s2_tvalid  (s2_tvalid),
    .s2_tlast   (s2_tlast),
    .s2_tready  (s2_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant      (grant),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [14:0] out_bus;
  assign out_bus = {s1_tready, s2_tready, m_tvalid, m_tlast, m_tdata, grant, err_timeout};

  logic [DW:0]   s1_q[$];
  logic [DW:0]   s2_q[$];
  logic [DW+2:0] exp_q[$];
  bit            s1_en, s2_en;
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_beat(input int src, input bit last, input logic [DW-1:0] d, input bit expect_out);
    if (src == 1) s1_q.push_back({last, d});
    else          s2_q.push_back({last, d});
    if (expect_out) exp_q.push_back({(src == 1) ? 2'b01 : 2'b10, last, d});
  endtask

  // Called on a falling edge: drive sources from their queues, then sample the DUT.
  task automatic drive_sample(input bit rdy, output logic [1:0] g, output logic e);
    logic [DW+2:0] x;
    m_tready  = rdy;
    s1_tvalid = s1_en && (s1_q.size() > 0);
    s1_tdata  = s1_tvalid ? s1_q[0][DW-1:0] : '0;
    s1_tlast  = s1_tvalid ? s1_q[0][DW] : 1'b0;
    s2_tvalid = s2_en && (s2_q.size() > 0);
    s2_tdata  = s2_tvalid ? s2_q[0][DW-1:0] : '0;
    s2_tlast  = s2_tvalid ? s2_q[0][DW] : 1'b0;
    #1;
    g = grant;
    e = err_timeout;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check_eq("m_extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        x = exp_q.pop_front();
        check_eq("m_beat", {grant, m_tlast, m_tdata}, x);
      end
    end
    if (s1_tvalid && s1_tready) void'(s1_q.pop_front());
    if (s2_tvalid && s2_tready) void'(s2_q.pop_front());
  endtask

  task automatic step(input bit rdy, output logic [1:0] g, output logic e);
    drive_sample(rdy, g, e);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    s1_en = 1'b0;
    s2_en = 1'b0;
    s1_q.delete();
    s2_q.delete();
    exp_q.delete();
    m_tready  = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    s2_tvalid = 1'b0; s2_tdata = '0; s2_tlast = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(out_bus), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] g;
    logic       e;
    int unsigned g_rr[13]   = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0};
    int unsigned g_sb[13]   = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2, 0};
    int unsigned g_bp[11]   = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    bit          r_bp[11]   = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int unsigned g_rst[5]   = '{0, 1, 0, 2, 0};
`ifdef AXIS_ARB_TIMEOUT_EN
    int unsigned g_wd[9]    = '{0, 1, 1, 1, 1, 1, 0, 2, 0};
    int unsigned e_wd[9]    = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
`else
    int unsigned g_wd[9]    = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    int unsigned e_wd[9]    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Round robin with 3-beat packets, both sources requesting.
    apply_reset();
    for (int i = 0; i < 3; i++) push_beat(1, i == 2, 8'h10 + 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) push_beat(2, i == 2, 8'h20 + 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) push_beat(1, i == 2, 8'h30 + 8'(i), 1'b1);
    s1_en = 1'b1;
    s2_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, g, e);
      check_eq($sformatf("rr_grant_c%0d", i), 32'(g), g_rr[i]);
    end
    check_eq("rr_beats_left", 32'(exp_q.size()), 32'd0);

    // Single-beat packets alternating between sources.
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      push_beat(1, 1'b1, 8'h40 + 8'(k), 1'b1);
      push_beat(2, 1'b1, 8'h50 + 8'(k), 1'b1);
    end
    s1_en = 1'b1;
    s2_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, g, e);
      check_eq($sformatf("single_grant_c%0d", i), 32'(g), g_sb[i]);
    end
    check_eq("single_beats_left", 32'(exp_q.size()), 32'd0);

    // s2 alone, 4 beats, 5 cycles of backpressure mid-packet.
    apply_reset();
    for (int i = 0; i < 4; i++) push_beat(2, i == 3, 8'h60 + 8'(i), 1'b1);
    s2_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(r_bp[i], g, e);
      check_eq($sformatf("bp_grant_c%0d", i), 32'(g), g_bp[i]);
      check_eq($sformatf("bp_err_c%0d", i), 32'(e), 32'd0);
    end
    check_eq("bp_beats_left", 32'(exp_q.size()), 32'd0);

    // Reset asserted on beat 2 of a 5-beat s1 packet.
    apply_reset();
    for (int i = 0; i < 5; i++) push_beat(1, i == 4, 8'h80 + 8'(i), i < 2);
    s1_en = 1'b1;
    step(1'b1, g, e);
    step(1'b1, g, e);
    drive_sample(1'b1, g, e);
    check_eq("mid_rst_grant_before", 32'(g), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_outputs", 32'(out_bus), 32'd0);
    s1_q.delete();
    check_eq("mid_rst_beats_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    push_beat(1, 1'b1, 8'h70, 1'b1);
    push_beat(2, 1'b1, 8'h71, 1'b1);
    s2_en = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g, e);
      check_eq($sformatf("post_rst_grant_c%0d", i), 32'(g), g_rst[i]);
    end
    check_eq("post_rst_beats_left", 32'(exp_q.size()), 32'd0);

    // s1 stops mid-packet while s2 waits.
    apply_reset();
    push_beat(1, 1'b0, 8'h90, 1'b1);
    push_beat(1, 1'b0, 8'h91, 1'b0);
    push_beat(1, 1'b1, 8'h92, 1'b0);
`ifdef AXIS_ARB_TIMEOUT_EN
    push_beat(2, 1'b1, 8'hA0, 1'b1);
`else
    push_beat(2, 1'b1, 8'hA0, 1'b0);
`endif
    s1_en = 1'b1;
    s2_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) s1_en = 1'b0;
      step(1'b1, g, e);
      check_eq($sformatf("wd_grant_c%0d", i), 32'(g), g_wd[i]);
      check_eq($sformatf("wd_err_c%0d", i), 32'(e), e_wd[i]);
    end
    check_eq("wd_beats_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_arb_2_1.md
AXIS_ARB_2_1 -- requirements
Module: axis_arb_2_1

Interface
REQ-001 SHALL have parameter DW, default 8, meaning tdata width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning idle-cycle limit of the mid-packet watchdog (range 1..255).
REQ-003 SHALL have port clk  input  1  meaning single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have ports s1_tdata/s1_tvalid/s1_tlast  input  DW/1/1  meaning AXIS slave 1 data, valid and last.
REQ-006 SHALL have port s1_tready  output  1  meaning slave 1 ready.
REQ-007 SHALL have ports s2_tdata/s2_tvalid/s2_tlast  input  DW/1/1  meaning AXIS slave 2 data, valid and last.
REQ-008 SHALL have port s2_tready  output  1  meaning slave 2 ready.
REQ-009 SHALL have ports m_tdata/m_tvalid/m_tlast  output  DW/1/1  meaning AXIS master data, valid and last.
REQ-010 SHALL have port m_tready  input  1  meaning master ready.
REQ-011 SHALL have port grant  output  2  meaning one-hot current owner: bit0 is s1, bit1 is s2, 00 when idle.
REQ-012 SHALL have port err_timeout  output  1  meaning one-cycle pulse when the watchdog revokes a grant.

Function
REQ-013 SHALL implement an FSM with states IDLE, GNT1 and GNT2, using packet-granular round-robin arbitration.
REQ-014 In IDLE, SHALL hold s1_tready=0, s2_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0 and grant=00.
REQ-015 In IDLE with only sN_tvalid=1, SHALL enter GNTN on the next edge; arbitration latency is 1 cycle.
REQ-016 In IDLE with both valid, SHALL grant the source not served last; the last_served register holds s2 after reset, so s1 wins first.
REQ-017 In GNTN, SHALL pass through combinationally with zero latency: m_tdata=sN_tdata, m_tvalid=sN_tvalid, m_tlast=sN_tlast, sN_tready=m_tready; the other tready SHALL be 0.
REQ-018 In GNTN, SHALL keep ownership until a beat with sN_tvalid && m_tready && sN_tlast, then return to IDLE and set last_served=N.
REQ-019 After each packet, SHALL insert exactly one IDLE bubble cycle before the next grant; there is no direct GNT1-to-GNT2 transition.
REQ-020 SHALL give a single-beat packet (tlast on the first beat) a grant lasting exactly one accepted beat.
REQ-021 SHALL ignore the non-granted source's tvalid and tlast entirely while a grant is held.
REQ-022 With m_tready=0, SHALL keep the grant and hold the FSM state for any number of cycles; backpressure never triggers the watchdog.
REQ-023 SHALL drive grant from the FSM state register, glitch-free.

Reset
REQ-024 While rst=0, SHALL force state=IDLE, last_served=s2, watchdog count=0, err_timeout=0, and all outputs to the REQ-014 values, asynchronously.
REQ-025 On reset asserted mid-packet, SHALL abandon the packet without emitting tlast; after release, arbitration restarts per REQ-016.
REQ-026 SHALL synchronize reset release to the clk edge; the first arbitration decision is made on the first edge after rst=1.

Configuration
REQ-027 With macro AXIS_ARB_TIMEOUT_EN defined, the watchdog SHALL count consecutive cycles in GNTN with sN_tvalid=0, and clear the count on any sN_tvalid=1 cycle or on leaving GNTN.
REQ-028 With the macro defined, when the count reaches TIMEOUT, SHALL go to IDLE on that edge, set last_served=N, and pulse err_timeout for 1 cycle.
REQ-029 Without the macro, SHALL instantiate no counter, tie err_timeout to 0, and keep the port list identical.

Structure
REQ-030 Package axis_arb_pkg SHALL hold typedef enum arb_state_t {IDLE, GNT1, GNT2}, localparam GNT_NONE=2'b00, GNT_S1=2'b01 and GNT_S2=2'b10.
REQ-031 The watchdog SHALL be the sub-module axis_arb_wdog (parameter TIMEOUT; inputs clk, rst, en, stall; output expire), instantiated only under AXIS_ARB_TIMEOUT_EN.

Verification
REQ-032 Bench SHALL cover: both valid after reset, m_tready=1, 3-beat packets -> s1 packet (grant=01) first, 1 bubble, then s2 (grant=10), then s1 again.
REQ-033 Bench SHALL cover: only s2 valid, 4-beat packet with m_tready low for 5 cycles mid-packet -> grant=10 held throughout, no err_timeout, data order intact.
REQ-034 Bench SHALL cover: single-beat packets alternating on both sources -> pattern G1, IDLE, G2, IDLE ... with exactly one beat per grant.
REQ-035 Bench SHALL cover: rst=0 on beat 2 of a 5-beat s1 packet -> all outputs 0 within the same cycle; after release with both valid, s1 granted.
REQ-036 Bench SHALL cover, with AXIS_ARB_TIMEOUT_EN and TIMEOUT=4: s1 drops valid mid-packet -> err_timeout pulses on the 4th idle cycle, FSM goes to IDLE, pending s2 granted next.
REQ-037 Bench SHALL cover, without the macro: same stimulus as REQ-036 -> grant=01 held indefinitely and err_timeout stays 0.
